// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour command replayer: FSM states,
// command field constants and the move-bit order shared with the solver.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    localparam logic [4:0] LAST_MOVE = 5'd23;

    // Move bit i moves the knight by (MV_DX[i], MV_DY[i]); the solver encodes with this table.
    localparam logic signed [2:0] MV_DX [8] = '{-3'sd1, 3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1, 3'sd2, 3'sd2};
    localparam logic signed [2:0] MV_DY [8] = '{3'sd2, 3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1};

    function automatic logic [3:0] mag(input logic signed [2:0] v);
        logic [2:0] a;
        a = v[2] ? 3'(-v) : v;
        return {1'b0, a};
    endfunction

endpackage

// File: rtl/move_decode.sv
// Combinational decode of a one-hot knight move into its vertical and
// horizontal leg commands; non-one-hot moves decode to all-zero commands.
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic              one_hot;

    always_comb begin
        one_hot  = (move != '0) && ((move & (move - 8'd1)) == '0);
        dx       = '0;
        dy       = '0;
        vert_cmd = '0;
        horz_cmd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (move[i]) begin
                dx = MV_DX[i];
                dy = MV_DY[i];
            end
        end
        if (one_hot) begin
            vert_cmd = {OP_MOVE, (dy > 3'sd0) ? HEAD_N : HEAD_S, mag(dy)};
            horz_cmd = {OP_FANFARE, (dx > 3'sd0) ? HEAD_E : HEAD_W, mag(dx)};
        end
    end

endmodule

// File: rtl/tour_cmd.sv
// Command source mux: passes UART commands through when idle, otherwise
// replays a solved 24-move tour as vertical/horizontal leg commands.
module tour_cmd
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        clr_cmd_rdy_UART,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    state_t      state;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;

    move_decode u_move_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            case (state)
                IDLE:    if (start_tour) begin
                             mv_indx <= '0;
                             state   <= FETCH;
                         end
                FETCH:   state <= VERT;
                VERT:    if (clr_cmd_rdy) state <= HOLD_V;
                HOLD_V:  if (send_resp) state <= HORZ;
                HORZ:    if (clr_cmd_rdy) state <= HOLD_H;
                HOLD_H:  if (send_resp) begin
                             if (mv_indx == LAST_MOVE) begin
                                 state <= IDLE;
                             end else begin
                                 mv_indx <= mv_indx + 5'd1;
                                 state   <= FETCH;
                             end
                         end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state so IDLE stays a zero-latency UART pass-through.
    always_comb begin
        cmd              = '0;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_ACK;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            HOLD_V:  cmd = vert_cmd;
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                cmd = horz_cmd;
                if (mv_indx == LAST_MOVE) resp = RESP_ACK;
            end
            default: ;
        endcase
    end

endmodule
